// File: rtl/zero_flag_pkg.sv
// Shared types and elaboration helpers for the pipelined zero/flag detector.
// Optional macro ZERO_FLAG_FWD_EN is consumed by zero_flag_pipe.
package zero_flag_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic neg;
    logic c;
    logic v;
    logic sf;
  } sb_t;

  localparam logic [3:0] NZCV_RESET = 4'b0000;
  localparam int SB_W = $bits(sb_t);

  function automatic int clog_radix(
    input int width,
    input int radix
  );
    int l;
    longint p;
    l = 0;
    p = 1;
    while (p < longint'(width)) begin
      p = p * radix;
      l++;
    end
    return l;
  endfunction

  function automatic int ipow(
    input int b,
    input int e
  );
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Bit offset of tree level lvl inside the flattened term bus.
  function automatic int term_off(
    input int radix,
    input int levels,
    input int lvl
  );
    int o;
    o = 0;
    for (int m = 0; m < lvl; m++) o = o + ipow(radix, levels - m);
    return o;
  endfunction

endpackage

// File: rtl/or_reduce_stage.sv
// One level of the OR tree: registered OR of RADIX-wide groups,
// plus the entry valid bit and its side-band.
module or_reduce_stage #(
  parameter int IN_TERMS = 3,
  parameter int RADIX = 3,
  parameter int SB_W = 4,
  localparam int OUT_TERMS = IN_TERMS / RADIX
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [IN_TERMS-1:0]  i_terms,
  input  logic [SB_W-1:0]      i_sb,
  output logic                 o_valid,
  output logic [OUT_TERMS-1:0] o_terms,
  output logic [SB_W-1:0]      o_sb
);

  logic [OUT_TERMS-1:0] w_or;
  logic                 r_valid;
  logic [OUT_TERMS-1:0] r_terms;
  logic [SB_W-1:0]      r_sb;

  always_comb begin
    w_or = '0;
    for (int g = 0; g < OUT_TERMS; g++)
      w_or[g] = |i_terms[g*RADIX +: RADIX];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_terms <= '0;
      r_sb    <= '0;
    end else begin
      r_valid <= i_valid & ~i_flush;
      if (i_valid) begin
        r_terms <= w_or;
        r_sb    <= i_sb;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_terms = r_terms;
  assign o_sb    = r_sb;

endmodule

// File: rtl/zero_flag_pipe.sv
// Pipelined radix-RADIX zero detector with NZCV commit and hazard flag.
// Define ZERO_FLAG_FWD_EN to forward committing NZCV combinationally.
module zero_flag_pipe
  import zero_flag_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int RADIX = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_carry,
  input  logic             in_ovf,
  input  logic             in_set_flags,
  input  logic             flush,
  output logic             out_valid,
  output logic             out_zero,
  output logic             out_neg,
  output logic [3:0]       flags,
  output logic             pending
);

  localparam int LEVELS = clog_radix(WIDTH, RADIX);
  localparam int PAD    = ipow(RADIX, LEVELS);
  localparam int TOT    = term_off(RADIX, LEVELS, LEVELS + 1);

`ifdef ZERO_FLAG_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [TOT-1:0]  w_terms;
  logic [LEVELS:0] w_v;
  sb_t             w_sb [LEVELS+1];

  assign w_terms[0 +: PAD] = PAD'(in_data);
  assign w_v[0]  = in_valid;
  assign w_sb[0] = '{neg: in_data[WIDTH-1], c: in_carry,
                     v: in_ovf, sf: in_set_flags};

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NIN  = ipow(RADIX, LEVELS - k);
    localparam int NOUT = NIN / RADIX;
    localparam int OI   = term_off(RADIX, LEVELS, k);
    localparam int OO   = term_off(RADIX, LEVELS, k + 1);

    or_reduce_stage #(
      .IN_TERMS(NIN),
      .RADIX   (RADIX),
      .SB_W    (SB_W)
    ) u_stage (
      .clk    (clk),
      .reset_n(reset_n),
      .i_flush(flush),
      .i_valid(w_v[k]),
      .i_terms(w_terms[OI +: NIN]),
      .i_sb   (w_sb[k]),
      .o_valid(w_v[k+1]),
      .o_terms(w_terms[OO +: NOUT]),
      .o_sb   (w_sb[k+1])
    );
  end

  logic  w_last_v;
  logic  w_last_z;
  sb_t   w_last_sb;
  logic  w_commit;
  nzcv_t w_new;
  logic  w_pend;

  nzcv_t r_flags;
  logic  r_zero;
  logic  r_neg;

  assign w_last_v  = w_v[LEVELS];
  assign w_last_z  = ~w_terms[TOT-1];
  assign w_last_sb = w_sb[LEVELS];
  assign w_commit  = w_last_v & w_last_sb.sf & ~flush;
  assign w_new     = '{n: w_last_sb.neg, z: w_last_z,
                       c: w_last_sb.c, v: w_last_sb.v};

  // With forwarding the last stage is already visible via flags.
  always_comb begin
    w_pend = 1'b0;
    for (int k = 1; k <= LEVELS; k++)
      if (k < LEVELS || !FWD_EN)
        w_pend = w_pend | (w_v[k] & w_sb[k].sf);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= NZCV_RESET;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      if (w_commit) r_flags <= w_new;
      if (w_last_v) begin
        r_zero <= w_last_z;
        r_neg  <= w_last_sb.neg;
      end
    end
  end

  assign out_valid = w_last_v;
  assign out_zero  = w_last_v ? w_last_z : r_zero;
  assign out_neg   = w_last_v ? w_last_sb.neg : r_neg;
  assign flags     = (FWD_EN && w_commit) ? w_new : r_flags;
  assign pending   = w_pend;

endmodule

// File: tb/tb_zero_flag_pipe.sv
// Self-checking bench for zero_flag_pipe (WIDTH=64, RADIX=3, LEVELS=4):
// hand-derived vector table, corner sequences and a history-based model.
module tb_zero_flag_pipe;

  localparam int L = 4;
`ifdef ZERO_FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_carry = 1'b0;
  logic        in_ovf = 1'b0;
  logic        in_set_flags = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid, out_zero, out_neg, pending;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  zero_flag_pipe dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_carry    (in_carry),
    .in_ovf      (in_ovf),
    .in_set_flags(in_set_flags),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .flags       (flags),
    .pending     (pending)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Issue history: entry accepted in cycle t is seen at the output
  // in cycle t+L unless a flush or reset killed it meanwhile.
  typedef struct {
    bit          vis;
    bit          sf;
    logic [63:0] d;
    bit          c;
    bit          o;
  } ent_t;

  ent_t       hist[1024];
  int         cyc = 0;
  logic [3:0] mf = 4'b0000;
  logic       mz = 1'b0;
  logic       mn = 1'b0;

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic        c, o, sf, fl;
    logic        ov, z, n;
    logic [3:0]  fr, ff;
    logic        pr, pf;
  } vec_t;

  vec_t tbl[20];
  vec_t nov;

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) hist[i].vis = 1'b0;
    mf = 4'b0000;
    mz = 1'b0;
    mn = 1'b0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cyc_run(input logic iv, input logic [63:0] d,
                         input logic c, input logic o,
                         input logic sf, input logic fl,
                         input bit has_tv, input vec_t tv);
    int         j;
    logic       e_ov, e_z, e_n, e_p, cm;
    logic [3:0] nf, e_f;
    in_valid = iv; in_data = d; in_carry = c;
    in_ovf = o; in_set_flags = sf; flush = fl;
    if (cyc >= 1024) begin
      $display("FAIL cycle_budget: got %0d, expected <1024", cyc);
      $fatal(1);
    end
    j = cyc - L;
    e_ov = (j >= 0) && hist[j].vis;
    e_z = e_ov ? (hist[j].d == 64'd0) : mz;
    e_n = e_ov ? hist[j].d[63] : mn;
    e_p = 1'b0;
    for (int k = 1; k <= L; k++)
      if (cyc - k >= 0 && hist[cyc-k].vis && hist[cyc-k].sf
          && (k < L || !FWD)) e_p = 1'b1;
    cm = e_ov && hist[j].sf && !fl;
    nf = e_ov ? {e_n, e_z, hist[j].c, hist[j].o} : 4'b0000;
    e_f = (FWD && cm) ? nf : mf;
    hist[cyc].vis = iv && !fl;
    hist[cyc].sf = sf;
    hist[cyc].d = d;
    hist[cyc].c = c;
    hist[cyc].o = o;
    if (fl)
      for (int k = 1; k < L; k++)
        if (cyc - k >= 0) hist[cyc-k].vis = 1'b0;
    @(negedge clk);
    chk("out_valid", out_valid, e_ov);
    chk("out_zero", out_zero, e_z);
    chk("out_neg", out_neg, e_n);
    chk("flags", flags, e_f);
    chk("pending", pending, e_p);
    if (has_tv) begin
      chk("tbl_out_valid", out_valid, tv.ov);
      chk("tbl_out_zero", out_zero, tv.z);
      chk("tbl_out_neg", out_neg, tv.n);
      chk("tbl_flags", flags, FWD ? tv.ff : tv.fr);
      chk("tbl_pending", pending, FWD ? tv.pf : tv.pr);
    end
    @(posedge clk);
    if (cm) mf = nf;
    if (e_ov) begin
      mz = e_z;
      mn = e_n;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc_run(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nov);
  endtask

  task automatic issue(input logic [63:0] d, input logic c,
                       input logic o, input logic sf);
    cyc_run(1'b1, d, c, o, sf, 1'b0, 1'b0, nov);
  endtask

  function automatic vec_t mk(
    input logic iv, input logic [63:0] d, input logic c,
    input logic o, input logic sf, input logic fl,
    input logic ov, input logic z, input logic n,
    input logic [3:0] fr, input logic [3:0] ff,
    input logic pr, input logic pf);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.o = o; v.sf = sf; v.fl = fl;
    v.ov = ov; v.z = z; v.n = n; v.fr = fr; v.ff = ff;
    v.pr = pr; v.pf = pf;
    return v;
  endfunction

  initial begin
    logic [63:0] rd;
    logic        riv, rfl;
    nov = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
    // single zero entry with carry
    tbl[0]  = mk(1, 64'd0, 1, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
    tbl[1]  = mk(0, 64'd0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1);
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = mk(0, 64'd0, 0, 0, 0, 0, 1, 1, 0, 4'h0, 4'h6, 1, 0);
    tbl[5]  = mk(0, 64'd0, 0, 0, 0, 0, 0, 1, 0, 4'h6, 4'h6, 0, 0);
    // back-to-back A=0/sf, B=5/no sf, C=-1/sf
    tbl[6]  = mk(1, 64'd0, 0, 0, 1, 0, 0, 1, 0, 4'h6, 4'h6, 0, 0);
    tbl[7]  = mk(1, 64'd5, 0, 0, 0, 0, 0, 1, 0, 4'h6, 4'h6, 1, 1);
    tbl[8]  = mk(1, '1, 0, 0, 1, 0, 0, 1, 0, 4'h6, 4'h6, 1, 1);
    tbl[9]  = mk(0, 64'd0, 0, 0, 0, 0, 0, 1, 0, 4'h6, 4'h6, 1, 1);
    tbl[10] = mk(0, 64'd0, 0, 0, 0, 0, 1, 1, 0, 4'h6, 4'h4, 1, 1);
    tbl[11] = mk(0, 64'd0, 0, 0, 0, 0, 1, 0, 0, 4'h4, 4'h4, 1, 1);
    tbl[12] = mk(0, 64'd0, 0, 0, 0, 0, 1, 0, 1, 4'h4, 4'h8, 1, 0);
    tbl[13] = mk(0, 64'd0, 0, 0, 0, 0, 0, 0, 1, 4'h8, 4'h8, 0, 0);
    // flush two cycles after issue
    tbl[14] = mk(1, 64'd0, 0, 0, 1, 0, 0, 0, 1, 4'h8, 4'h8, 0, 0);
    tbl[15] = mk(0, 64'd0, 0, 0, 0, 0, 0, 0, 1, 4'h8, 4'h8, 1, 1);
    tbl[16] = mk(0, 64'd0, 0, 0, 0, 1, 0, 0, 1, 4'h8, 4'h8, 1, 1);
    tbl[17] = mk(0, 64'd0, 0, 0, 0, 0, 0, 0, 1, 4'h8, 4'h8, 0, 0);
    tbl[18] = tbl[17];
    tbl[19] = tbl[17];

    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_pending", pending, 1'b0);
    chk("rst_out_zero", out_zero, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(10);

    for (int i = 0; i < 20; i++)
      cyc_run(tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].o,
              tbl[i].sf, tbl[i].fl, 1'b1, tbl[i]);

    // walking one, then MSB with carry
    for (int i = 0; i < 64; i++) issue(64'd1 << i, 1'b0, 1'b0, 1'b1);
    issue(64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
    idle(L + 1);
    chk("walk_flags", flags, 4'b1010);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: rd = 64'd0;
        1: rd = 64'd1 << $urandom_range(0, 63);
        default: rd = {$urandom, $urandom};
      endcase
      riv = ($urandom_range(0, 3) != 0);
      rfl = ($urandom_range(0, 15) == 0);
      cyc_run(riv, rd, 1'($urandom), 1'($urandom), 1'($urandom),
              rfl, 1'b0, nov);
    end
    idle(L + 1);

    // async reset with three flag setters in flight
    issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    idle(L + 1);
    issue(64'd0, 1'b1, 1'b1, 1'b1);
    issue(64'd7, 1'b0, 1'b1, 1'b1);
    issue(64'd0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_pending", pending, 1'b0);
    chk("arst_flags", flags, 4'b0000);
    chk("arst_out_neg", out_neg, 1'b0);
    reset_n = 1'b1;
    model_clear();
    idle(L + 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zero_flag_pipe.md
Name: zero_flag_pipe

Overview:
- Pipelined, parametrised zero/flag detector for the ALU result path of the CPU datapath.
- Reduces a WIDTH-bit result through a radix-RADIX OR tree, with one register stage per tree level.
- Carries N/C/V alongside each result and commits NZCV into an architectural flag register when the instruction sets flags.
- Drives a `pending` hazard signal so the control unit can stall conditional branches while flag-setting results are still in flight.

Parameters:
- WIDTH, 64: result width in bits; any value >= 2.
- RADIX, 3: OR fan-in per tree node; valid range 2..8.
- LEVELS, derived: smallest L with RADIX**L >= WIDTH. Equals 4 at the defaults. Localparam, not overridable.

Ports:
- clk, input, 1: system clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: in_data and its side-band are valid this cycle.
- in_data, input, WIDTH: ALU result.
- in_carry, input, 1: ALU carry out.
- in_ovf, input, 1: ALU signed overflow.
- in_set_flags, input, 1: the instruction writes NZCV (S-suffix ops).
- flush, input, 1: kill every in-flight entry (branch mispredict or exception).
- out_valid, input... correction: out_valid, output, 1: result of the entry leaving the last stage is valid.
- out_zero, output, 1: 1 when that entry's in_data was all zeros.
- out_neg, output, 1: in_data[WIDTH-1] of that entry.
- flags, output, 4: architectural {N,Z,C,V}, registered.
- pending, output, 1: at least one valid in-flight entry has set_flags=1.

Behaviour:
- Reset (reset_n=0, asynchronous): all stage valid bits = 0, out_valid = 0, out_zero = 0, out_neg = 0, flags = 4'b0000, pending = 0. Reset asserted mid-operation discards all in-flight entries immediately.
- Padding: in_data is zero-extended to RADIX**LEVELS bits. Padding bits never affect Z.
- Stage k (1..LEVELS): ORs each group of RADIX partial terms from stage k-1 and registers them. Stage 1 consumes the padded in_data. Each stage also registers valid, neg, carry, ovf and set_flags.
- Latency: exactly LEVELS cycles from in_valid sampled high to out_valid high. Throughput is 1 entry per cycle, with no backpressure.
- Zero flag: out_zero = ~(final OR term), qualified by out_valid. When out_valid=0, out_zero and out_neg hold their previous values.
- Flag commit: on the cycle the last stage holds a valid entry with set_flags=1, flags <= {neg, zero, carry, ovf} at the next edge. Entries with set_flags=0 leave flags unchanged.
- pending: OR over all stages of (valid & set_flags), including the last stage, until its commit edge.
- flush: synchronous. At the edge, clears every stage valid bit, including the entry that would commit on that edge, so flags are not updated. An in_valid presented in the same cycle as flush is also dropped. flags keeps its previously committed value.
- Back-to-back flag setters: commits apply in order, one per cycle. The last one wins.
- No state machine beyond the valid shift chain. The pipeline is a pure register chain.

Optional Feature:
- Macro: ZERO_FLAG_FWD_EN.
- Defined: flags is a combinational forward of the committing entry's NZCV during its commit cycle (flags register still updates at the edge). Effective commit latency is LEVELS cycles instead of LEVELS+1. pending deasserts in the commit cycle.
- Undefined: flags is purely registered. New NZCV is visible one cycle after out_valid.

Decomposition:
- Shared package zero_flag_pkg:
  - typedef nzcv_t, packed struct {n, z, c, v}.
  - function clog_radix(width, radix), used to compute LEVELS.
  - localparam NZCV_RESET = 4'b0000.
- One natural sub-module: or_reduce_stage.
  - Parameters IN_TERMS, RADIX.
  - Registered OR of groups plus a valid bit, with asynchronous active-low reset.
  - Instantiated LEVELS times in a generate loop.

Test Plan (WIDTH=64, RADIX=3, LEVELS=4):
- Reset then idle: hold reset_n=0 for 2 cycles, release. flags=0000, out_valid=0 and pending=0 for 10 cycles.
- Zero detect, single entry: in_data=0, set_flags=1, carry=1, ovf=0 at cycle 0. Expect out_valid=1 and out_zero=1 at cycle 4, flags=0110 at cycle 5 (cycle 4 with ZERO_FLAG_FWD_EN), pending=1 during cycles 1..4.
- Single high bit per position: stream in_data = 1<<i for i=0..63, then 64'h8000_0000_0000_0000, set_flags=1. Every out_zero=0. The last entry gives flags N=1, Z=0. Confirms padding and MSB handling.
- Back-to-back with mixed set_flags: entries A=0/sf=1, B=5/sf=0, C=-1/sf=1. flags goes 0100 then stays, then 1000. pending stays 1 until C commits.
- Flush mid-flight: issue in_data=0/sf=1, assert flush at cycle 2. No out_valid, flags unchanged, pending=0 after the edge.
- Async reset mid-flight: three valid entries in flight, pulse reset_n low between edges. Outputs clear immediately and no commits occur afterward.
